scene_ctrl: RTL and testbench

Scene controller directly upstream of the VGA display stage. It turns a raw, bouncy pushbutton into a clean scene-switch request. An optional auto-advance timer produces the same request. Every switch is applied only at a vertical-sync frame boundary, so the picture select (`o_state`, wired to the display stage's `i_state`) never changes mid-frame and no torn frame reaches the screen.

---
 rtl/scene_ctrl_if.sv | 27 ++
 rtl/scene_ctrl.sv | 131 +++++++++++++
 tb/tb_scene_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/scene_ctrl_if.sv
// Scene controller signal bundle: key/VS/auto-enable in, picture select and frame status out.
interface scene_ctrl_if;
  logic       i_key;
  logic       i_vs;
  logic       i_auto_en;
  logic       o_state;
  logic       o_switch;
  logic [7:0] o_frame_cnt;

  modport master (
    output i_key,
    output i_vs,
    output i_auto_en,
    input  o_state,
    input  o_switch,
    input  o_frame_cnt
  );

  modport slave (
    input  i_key,
    input  i_vs,
    input  i_auto_en,
    output o_state,
    output o_switch,
    output o_frame_cnt
  );
endinterface

// File: rtl/scene_ctrl.sv
// Debounced pushbutton / auto-advance scene switcher; applies picture changes only at
// the VS falling edge so the display stage never shows a torn frame.
module scene_ctrl #(
  parameter logic [19:0] DEB_CYCLES  = 20'd1000000,
  parameter logic [7:0]  AUTO_FRAMES = 8'd0
) (
  input  logic          clk,
  input  logic          rst,
  scene_ctrl_if.slave   bus
);

  localparam int unsigned    CW        = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  DEB_LAST  = CW'(DEB_CYCLES - 20'd1);
  localparam logic [7:0]     AUTO_LAST = AUTO_FRAMES - 8'd1;
  localparam logic           AUTO_ON   = (AUTO_FRAMES != 8'd0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } deb_state_e;

  logic          key_meta_q;
  logic          key_sync_q;
  deb_state_e    deb_state_q, deb_state_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          vs_q;
  logic          pending_q, pending_d;
  logic          state_q, state_d;
  logic          switch_q, switch_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic          press_req;
  logic          frame_start;
  logic          auto_hit;
  logic          do_switch;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_q  <= 1'b1;
      key_sync_q  <= 1'b1;
      deb_state_q <= IDLE;
      deb_cnt_q   <= '0;
      vs_q        <= 1'b0;
      pending_q   <= 1'b0;
      state_q     <= 1'b0;
      switch_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      key_meta_q  <= bus.i_key;
      key_sync_q  <= key_meta_q;
      deb_state_q <= deb_state_d;
      deb_cnt_q   <= deb_cnt_d;
      vs_q        <= bus.i_vs;
      pending_q   <= pending_d;
      state_q     <= state_d;
      switch_q    <= switch_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // press_req fires on the DEB_PRESS -> HELD transition only, so one request per press
  always_comb begin
    deb_state_d = deb_state_q;
    deb_cnt_d   = deb_cnt_q;
    press_req   = 1'b0;
    unique case (deb_state_q)
      IDLE: begin
        if (!key_sync_q) begin
          deb_state_d = DEB_PRESS;
          deb_cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (key_sync_q) begin
          deb_state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_state_d = HELD;
          press_req   = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (key_sync_q) begin
          deb_state_d = DEB_REL;
          deb_cnt_d   = '0;
        end
      end
      DEB_REL: begin
        if (!key_sync_q) begin
          deb_state_d = HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_state_d = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + CW'(1);
        end
      end
      default: begin
        deb_state_d = IDLE;
        deb_cnt_d   = '0;
      end
    endcase
  end

  assign frame_start = vs_q & ~bus.i_vs;
  assign auto_hit    = bus.i_auto_en & AUTO_ON & frame_start & (frame_cnt_q == AUTO_LAST);
  // press_req is folded in directly so a request coinciding with frame_start switches now
  assign do_switch   = frame_start & (pending_q | press_req | auto_hit);

  always_comb begin
    pending_d   = pending_q;
    state_d     = state_q;
    switch_d    = do_switch;
    frame_cnt_d = frame_cnt_q;
    if (press_req) pending_d = 1'b1;
    if (do_switch) begin
      pending_d   = 1'b0;
      state_d     = ~state_q;
      frame_cnt_d = '0;
    end else if (frame_start && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  assign bus.o_state     = state_q;
  assign bus.o_switch    = switch_q;
  assign bus.o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_scene_ctrl.sv
// Directed bench for scene_ctrl: VS low 6 of every 20 cycles, DEB_CYCLES=4, AUTO_FRAMES=3.
module tb_scene_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   sw_cnt;
  int   sw0;
  int   phase;

  scene_ctrl_if bus ();

  scene_ctrl #(
    .DEB_CYCLES (20'd4),
    .AUTO_FRAMES(8'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: sample at the falling edge, then advance the VS pattern (low in phases 0..5)
  task automatic tick();
    @(negedge clk);
    if (bus.o_switch === 1'b1) sw_cnt++;
    phase    = (phase == 19) ? 0 : phase + 1;
    bus.i_vs = (phase < 6) ? 1'b0 : 1'b1;
  endtask

  // Returns right after the outputs of the next frame_start are visible (phase 1)
  task automatic run_to_frame();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (phase == 1) break;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int exp_cnt [6] = '{1, 2, 0, 1, 2, 0};
  int exp_st  [6] = '{1, 1, 0, 0, 0, 1};
  int exp_sw  [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    total = 0; bad = 0; sw_cnt = 0; phase = 8;
    rst = 1'b1;
    bus.i_key = 1'b1; bus.i_vs = 1'b1; bus.i_auto_en = 1'b0;

    // 1. reset and free-running frame count
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_state", bus.o_state, 0);
    chk("rst_switch", bus.o_switch, 0);
    chk("rst_cnt", bus.o_frame_cnt, 0);
    chk("rst_pending", dut.pending_q, 0);
    chk("rst_fsm", 32'(dut.deb_state_q), 0);
    for (int f = 1; f <= 5; f++) begin
      run_to_frame();
      chk($sformatf("t1_cnt%0d", f), bus.o_frame_cnt, f);
      chk($sformatf("t1_state%0d", f), bus.o_state, 0);
    end
    chk("t1_no_switch", sw_cnt, 0);

    // 2. clean press from mid-frame
    repeat (9) tick();
    bus.i_key = 1'b0; sw0 = sw_cnt;
    repeat (10) tick();
    chk("t2_not_early", sw_cnt - sw0, 0);
    chk("t2_pending", dut.pending_q, 1);
    tick();
    chk("t2_pulse", bus.o_switch, 1);
    chk("t2_state", bus.o_state, 1);
    chk("t2_cnt", bus.o_frame_cnt, 0);
    chk("t2_pending_clr", dut.pending_q, 0);
    repeat (19) tick();
    bus.i_key = 1'b1;
    run_to_frame();
    chk("t2_one_switch", sw_cnt - sw0, 1);
    chk("t2_cnt_after", bus.o_frame_cnt, 1);

    // 3. bounce rejection, then a long hold
    sw0 = sw_cnt;
    for (int b = 0; b < 8; b++) begin
      bus.i_key = b[1];
      tick();
    end
    bus.i_key = 1'b1;
    repeat (8) tick();
    chk("t3_bounce_fsm", 32'(dut.deb_state_q), 0);
    chk("t3_bounce_nosw", sw_cnt - sw0, 0);
    chk("t3_bounce_pend", dut.pending_q, 0);
    bus.i_key = 1'b0;
    repeat (100) tick();
    bus.i_key = 1'b1;
    repeat (10) tick();
    chk("t3_hold_one", sw_cnt - sw0, 1);
    chk("t3_state", bus.o_state, 0);
    chk("t3_fsm_idle", 32'(dut.deb_state_q), 0);
    run_to_frame();

    // 4. two debounced presses in one frame collapse into one toggle
    sw0 = sw_cnt;
    bus.i_key = 1'b0; repeat (6) tick();
    bus.i_key = 1'b1; repeat (6) tick();
    chk("t4_pending_mid", dut.pending_q, 1);
    bus.i_key = 1'b0; repeat (7) tick();
    chk("t4_not_early", sw_cnt - sw0, 0);
    tick();
    chk("t4_pulse", bus.o_switch, 1);
    chk("t4_state", bus.o_state, 1);
    bus.i_key = 1'b1;
    repeat (10) tick();
    chk("t4_single", sw_cnt - sw0, 1);
    chk("t4_pending_clr", dut.pending_q, 0);
    chk("t4_cnt", bus.o_frame_cnt, 0);

    // 5. auto-advance every 3rd frame, then a manual press restarts the period
    bus.i_auto_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      run_to_frame();
      chk($sformatf("t5_cnt%0d", f), bus.o_frame_cnt, exp_cnt[f]);
      chk($sformatf("t5_state%0d", f), bus.o_state, exp_st[f]);
      chk($sformatf("t5_sw%0d", f), bus.o_switch, exp_sw[f]);
    end
    bus.i_key = 1'b0; repeat (8) tick();
    bus.i_key = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run_to_frame();
      chk($sformatf("t5p_cnt%0d", f), bus.o_frame_cnt, exp_cnt[(f + 2) % 3]);
      chk($sformatf("t5p_state%0d", f), bus.o_state, (f == 3) ? 1 : 0);
    end
    bus.i_auto_en = 1'b0;

    // 6b. reset while a request is pending
    sw0 = sw_cnt;
    bus.i_key = 1'b0; repeat (8) tick();
    chk("t6r_pending", dut.pending_q, 1);
    bus.i_key = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("t6r_state", bus.o_state, 0);
    chk("t6r_pend_clr", dut.pending_q, 0);
    chk("t6r_cnt", bus.o_frame_cnt, 0);
    run_to_frame();
    chk("t6r_no_switch", sw_cnt - sw0, 0);
    chk("t6r_state_after", bus.o_state, 0);
    chk("t6r_cnt_after", bus.o_frame_cnt, 1);

    // 6a. press_req lands exactly on frame_start
    repeat (13) tick();
    sw0 = sw_cnt;
    bus.i_key = 1'b0;
    repeat (6) tick();
    chk("t6c_not_early", sw_cnt - sw0, 0);
    tick();
    chk("t6c_pulse", bus.o_switch, 1);
    chk("t6c_state", bus.o_state, 1);
    chk("t6c_cnt", bus.o_frame_cnt, 0);
    chk("t6c_pending", dut.pending_q, 0);
    repeat (3) tick();
    bus.i_key = 1'b1;
    repeat (10) tick();
    run_to_frame();
    chk("t6c_single", sw_cnt - sw0, 1);

    // frame counter saturation
    sw0 = sw_cnt;
    repeat (258) run_to_frame();
    chk("sat_cnt", bus.o_frame_cnt, 255);
    chk("sat_state", bus.o_state, 1);
    chk("sat_nosw", sw_cnt - sw0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
